crossing_request_scheduler: RTL and testbench

- Decides when the pedestrian crossing controller may start a pedestrian phase.
- Latches debounced button presses and enforces a minimum road green time.
- Extends road green while vehicles are detected, bounded by a maximum pedestrian wait.
- Issues a level start request to the crossing controller, handshaking against its busy flag. Sits between the button debouncer / road detector and the crossing controller.

---
 rtl/crossing_request_scheduler.sv | 157 +++++++++++++++
 tb/tb_crossing_request_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crossing_request_scheduler.sv
// Pedestrian crossing request scheduler.
// Latches button requests, enforces minimum road green and a vehicle gap before
// granting, forces a grant after a bounded wait, and handshakes a level start
// request against the crossing controller's busy flag.
// Optional: define SCHED_SERVE_COUNT_EN to add the saturating serve_count output.
module crossing_request_scheduler #(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned MIN_GREEN_T = 10,
    parameter int unsigned GAP_T       = 3,
    parameter int unsigned MAX_WAIT_T  = 30,
    parameter int unsigned ACK_TO_T    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_req,
    input  logic       road_det,
    input  logic       ctrl_busy,
    output logic       ped_start,
    output logic       req_pending,
    output logic       ack_fault,
`ifdef SCHED_SERVE_COUNT_EN
    output logic [7:0] serve_count,
`endif
    output logic [1:0] sched_state
);

    typedef enum logic [1:0] {
        StGreen   = 2'd0,
        StPending = 2'd1,
        StGrant   = 2'd2,
        StServing = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        ack_fault_q, ack_fault_d;
    logic        road_meta_q, road_det_s_q;
    logic [31:0] presc_q, presc_d;
    logic [31:0] green_cnt_q, green_cnt_d;
    logic [31:0] gap_cnt_q, gap_cnt_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic [31:0] ack_cnt_q, ack_cnt_d;
    logic        tick;
    logic        grant_ok;

    // Counters hold at their limit instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
        return (v >= lim) ? v : v + 32'd1;
    endfunction

    assign tick     = (presc_q == TICK_DIV - 1);
    assign grant_ok = (green_cnt_q >= MIN_GREEN_T) &&
                      ((gap_cnt_q >= GAP_T) || (wait_cnt_q >= MAX_WAIT_T));

    // Next-state decode and sticky acknowledge fault.
    always_comb begin
        state_d     = state_q;
        ack_fault_d = ack_fault_q;
        case (state_q)
            StGreen: begin
                if (ped_req) state_d = StPending;
            end
            StPending: begin
                if (grant_ok) state_d = StGrant;
            end
            StGrant: begin
                // A busy controller wins over a timeout expiring in the same cycle.
                if (ctrl_busy) begin
                    state_d = StServing;
                end else if (ack_cnt_q >= ACK_TO_T) begin
                    state_d     = StPending;
                    ack_fault_d = 1'b1;
                end
            end
            StServing: begin
                if (!ctrl_busy) state_d = StGreen;
            end
            default: state_d = StGreen;
        endcase
    end

    // Timebase prescaler and tick-driven counters.
    always_comb begin
        presc_d     = tick ? 32'd0 : presc_q + 32'd1;

        green_cnt_d = green_cnt_q;
        if (state_q == StServing && state_d == StGreen) begin
            green_cnt_d = 32'd0;
        end else if (tick && (state_q == StGreen || state_q == StPending)) begin
            green_cnt_d = sat_inc(green_cnt_q, MIN_GREEN_T);
        end

        gap_cnt_d = gap_cnt_q;
        if (road_det_s_q) begin
            gap_cnt_d = 32'd0;
        end else if (tick) begin
            gap_cnt_d = sat_inc(gap_cnt_q, GAP_T);
        end

        wait_cnt_d = wait_cnt_q;
        if (state_q == StGreen && ped_req) begin
            wait_cnt_d = 32'd0;
        end else if (tick && state_q == StPending) begin
            wait_cnt_d = sat_inc(wait_cnt_q, MAX_WAIT_T);
        end

        ack_cnt_d = 32'd0;
        if (state_q == StGrant) begin
            ack_cnt_d = tick ? sat_inc(ack_cnt_q, ACK_TO_T) : ack_cnt_q;
        end
    end

    // State, counters and road detector synchronizer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StGreen;
            ack_fault_q  <= 1'b0;
            road_meta_q  <= 1'b0;
            road_det_s_q <= 1'b0;
            presc_q      <= 32'd0;
            green_cnt_q  <= 32'd0;
            gap_cnt_q    <= 32'd0;
            wait_cnt_q   <= 32'd0;
            ack_cnt_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            ack_fault_q  <= ack_fault_d;
            road_meta_q  <= road_det;
            road_det_s_q <= road_meta_q;
            presc_q      <= presc_d;
            green_cnt_q  <= green_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            ack_cnt_q    <= ack_cnt_d;
        end
    end

`ifdef SCHED_SERVE_COUNT_EN
    logic [7:0] serve_q;

    // Count accepted grants, saturating at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            serve_q <= 8'd0;
        end else if (state_q == StGrant && ctrl_busy && serve_q != 8'hFF) begin
            serve_q <= serve_q + 8'd1;
        end
    end

    assign serve_count = serve_q;
`endif

    assign ped_start   = (state_q == StGrant);
    assign req_pending = (state_q == StPending) || (state_q == StGrant);
    assign ack_fault   = ack_fault_q;
    assign sched_state = state_q;

endmodule

// File: tb/tb_crossing_request_scheduler.sv
// Bench for crossing_request_scheduler with a 4-cycle tick.
// Edge E0 is the reset edge; counters advance on edges E4, E8, ...
module tb_crossing_request_scheduler;

    localparam int unsigned TICK_DIV    = 4;
    localparam int unsigned MIN_GREEN_T = 10;
    localparam int unsigned GAP_T       = 3;
    localparam int unsigned MAX_WAIT_T  = 20;
    localparam int unsigned ACK_TO_T    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ped_req = 1'b0;
    logic       road_det = 1'b0;
    logic       ctrl_busy = 1'b0;
    logic       ped_start;
    logic       req_pending;
    logic       ack_fault;
    logic [1:0] sched_state;
`ifdef SCHED_SERVE_COUNT_EN
    logic [7:0] serve_count;
`endif

    crossing_request_scheduler #(
        .TICK_DIV   (TICK_DIV),
        .MIN_GREEN_T(MIN_GREEN_T),
        .GAP_T      (GAP_T),
        .MAX_WAIT_T (MAX_WAIT_T),
        .ACK_TO_T   (ACK_TO_T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ped_req    (ped_req),
        .road_det   (road_det),
        .ctrl_busy  (ctrl_busy),
        .ped_start  (ped_start),
        .req_pending(req_pending),
        .ack_fault  (ack_fault),
`ifdef SCHED_SERVE_COUNT_EN
        .serve_count(serve_count),
`endif
        .sched_state(sched_state)
    );

    always #5 clk = ~clk;

    int unsigned cyc  = 0;
    int unsigned base = 0;
    int          total = 0;
    int          bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp,
                     int'(cyc - base));
        end
    endtask

    // Scoreboard: expected edge index of each ped_start rise.
    int sb_q[$];
    bit sb_en       = 1'b1;
    logic start_prev = 1'b0;
    int last_fall_k  = -1;

    always @(negedge clk) begin
        int k;
        int e;
        k = int'(cyc - base);
        if (sb_en && ped_start && !start_prev) begin
            if (sb_q.size() == 0) begin
                check("unexpected ped_start rise", k, -1);
            end else begin
                e = sb_q.pop_front();
                check("ped_start rise edge", k, e);
            end
        end
        if (!ped_start && start_prev) last_fall_k = k;
        start_prev = ped_start;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance to #1 after edge Ek.
    task automatic goto_edge(input int k);
        int guard = 0;
        while (int'(cyc - base) < k && guard < 100000) begin
            @(posedge clk);
            #1;
            guard++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst     = 1'b1;
        ped_req = 1'b0;
        @(posedge clk);
        #1;
        base = cyc;
        rst  = 1'b0;
        check("reset ped_start", ped_start, 0);
        check("reset req_pending", req_pending, 0);
        check("reset ack_fault", ack_fault, 0);
        check("reset sched_state", sched_state, 0);
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, " rises outstanding"}, sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic wait_state(input int code, input int budget, input string name);
        int n = 0;
        while (sched_state != code[1:0] && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, sched_state, code);
    endtask

    typedef struct {
        int press_k;
        bit road_init;
        int drop_k;
        bit busy_pre;
        int exp_k;
    } vec_t;

    vec_t vecs[6];

    initial begin
        // Press at tick 12, clear road: grant one edge after latch.
        vecs[0] = '{press_k: 48, road_init: 1'b0, drop_k: 0,  busy_pre: 1'b0, exp_k: 49};
        // Press at tick 2: wait for green_cnt=10 at E40.
        vecs[1] = '{press_k: 8,  road_init: 1'b0, drop_k: 0,  busy_pre: 1'b0, exp_k: 41};
        // Continuous vehicles: wait_cnt=20 at E48+4+76=E128.
        vecs[2] = '{press_k: 48, road_init: 1'b1, drop_k: 0,  busy_pre: 1'b0, exp_k: 129};
        // Vehicles clear at wait tick 5: synced at E70, gap=3 at E80.
        vecs[3] = '{press_k: 48, road_init: 1'b1, drop_k: 68, busy_pre: 1'b0, exp_k: 81};
        // Controller already busy: exactly one cycle in GRANT.
        vecs[4] = '{press_k: 48, road_init: 1'b0, drop_k: 0,  busy_pre: 1'b1, exp_k: 49};
        // Press on the edge min green is reached: latch first, grant next edge.
        vecs[5] = '{press_k: 40, road_init: 1'b0, drop_k: 0,  busy_pre: 1'b0, exp_k: 41};

        for (int i = 0; i < 6; i++) begin
            road_det  = vecs[i].road_init;
            ctrl_busy = vecs[i].busy_pre;
            do_reset();
            goto_edge(vecs[i].press_k - 1);
            ped_req = 1'b1;
            sb_q.push_back(vecs[i].exp_k);
            goto_edge(vecs[i].press_k);
            ped_req = 1'b0;
            check($sformatf("v%0d latch state", i), sched_state, 1);
            check($sformatf("v%0d latch req_pending", i), req_pending, 1);
            if (vecs[i].drop_k > 0) begin
                goto_edge(vecs[i].drop_k);
                road_det = 1'b0;
            end
            drain(200, $sformatf("v%0d grant", i));
            if (!vecs[i].busy_pre) begin
                ctrl_busy = 1'b1;
                step(1);
            end
            check($sformatf("v%0d serving state", i), sched_state, 3);
            check($sformatf("v%0d serving ped_start", i), ped_start, 0);
            check($sformatf("v%0d serving req_pending", i), req_pending, 0);
            // Presses while serving must be dropped.
            step(1);
            ped_req = 1'b1;
            step(1);
            ped_req = 1'b0;
            step(1);
            if (vecs[i].busy_pre) begin
                check($sformatf("v%0d ped_start fall edge", i), last_fall_k, vecs[i].exp_k + 1);
            end
            ctrl_busy = 1'b0;
            step(1);
            check($sformatf("v%0d return state", i), sched_state, 0);
            step(3);
            check($sformatf("v%0d no relatch state", i), sched_state, 0);
            check($sformatf("v%0d no relatch req_pending", i), req_pending, 0);
        end

        // Acknowledge timeout, regrant, then min green restarts after serving.
        road_det  = 1'b0;
        ctrl_busy = 1'b0;
        do_reset();
        goto_edge(47);
        ped_req = 1'b1;
        sb_q.push_back(49);
        sb_q.push_back(58);
        goto_edge(48);
        ped_req = 1'b0;
        goto_edge(56);
        check("ack pre-timeout state", sched_state, 2);
        check("ack pre-timeout fault", ack_fault, 0);
        goto_edge(57);
        check("ack timeout state", sched_state, 1);
        check("ack timeout fault", ack_fault, 1);
        check("ack timeout ped_start", ped_start, 0);
        check("ack timeout req_pending", req_pending, 1);
        goto_edge(58);
        check("regrant state", sched_state, 2);
        goto_edge(59);
        ctrl_busy = 1'b1;
        goto_edge(60);
        check("after-fault serving", sched_state, 3);
        check("fault sticky serving", ack_fault, 1);
        ctrl_busy = 1'b0;
        goto_edge(61);
        check("after-fault green", sched_state, 0);
        check("fault sticky green", ack_fault, 1);
        drain(4, "ack sequence");
        ped_req = 1'b1;
        sb_q.push_back(101);
        goto_edge(62);
        ped_req = 1'b0;
        drain(60, "green restart");
        ctrl_busy = 1'b1;
        step(1);
        ctrl_busy = 1'b0;
        step(1);

        // Reset while in GRANT drops the grant and restarts min green.
        do_reset();
        check("reset clears fault", ack_fault, 0);
        goto_edge(47);
        ped_req = 1'b1;
        sb_q.push_back(49);
        goto_edge(48);
        ped_req = 1'b0;
        goto_edge(49);
        check("pre-reset ped_start", ped_start, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        base = cyc;
        rst  = 1'b0;
        check("mid-grant reset ped_start", ped_start, 0);
        check("mid-grant reset req_pending", req_pending, 0);
        check("mid-grant reset ack_fault", ack_fault, 0);
        check("mid-grant reset state", sched_state, 0);
        goto_edge(7);
        ped_req = 1'b1;
        sb_q.push_back(41);
        goto_edge(8);
        ped_req = 1'b0;
        drain(60, "post-reset grant");
        ctrl_busy = 1'b1;
        step(1);
        ctrl_busy = 1'b0;
        step(2);
        check("post-reset return", sched_state, 0);

`ifdef SCHED_SERVE_COUNT_EN
        // Serve counter: 3 serves, then saturation.
        sb_en = 1'b0;
        do_reset();
        check("serve_count reset", serve_count, 0);
        for (int n = 1; n <= 260; n++) begin
            ped_req = 1'b1;
            step(1);
            ped_req = 1'b0;
            wait_state(2, 100, "serve grant");
            ctrl_busy = 1'b1;
            wait_state(3, 10, "serve serving");
            ctrl_busy = 1'b0;
            wait_state(0, 10, "serve green");
            if (n == 3) check("serve_count 3", serve_count, 3);
        end
        check("serve_count saturated", serve_count, 255);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
